// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-bit synchronous FIFO and sends each as an 8N1 UART frame.
// Outputs are registered from the next-state values, so they change in step with the state register.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] byte_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_e;

  state_e        r_state, w_nextState;
  logic [CW-1:0] r_clkCnt, w_nextClkCnt;
  logic [2:0]    r_bitIdx, w_nextBitIdx;
  logic [7:0]    r_shift, w_nextShift;
  logic [7:0]    r_byteCnt;
  logic          r_tx, r_rdEn, r_busy, r_txDone;
  logic          w_bitEnd, w_txNext;

  assign w_bitEnd = (r_clkCnt == LAST);

  always_comb begin
    w_nextState  = r_state;
    w_nextClkCnt = r_clkCnt;
    w_nextBitIdx = r_bitIdx;
    w_nextShift  = r_shift;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) w_nextState = REQ;
      end
      REQ: begin
        w_nextState = WAIT;
      end
      WAIT: begin
        // FIFO data is valid now, one cycle after the read strobe was sampled.
        w_nextShift  = fifo_data;
        w_nextClkCnt = '0;
        w_nextState  = START;
      end
      START: begin
        if (w_bitEnd) begin
          w_nextClkCnt = '0;
          w_nextBitIdx = '0;
          w_nextState  = DATA;
        end else begin
          w_nextClkCnt = r_clkCnt + CW'(1);
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_nextClkCnt = '0;
          w_nextShift  = {1'b0, r_shift[7:1]};
          if (r_bitIdx == 3'd7) w_nextState = STOP;
          else                  w_nextBitIdx = r_bitIdx + 3'd1;
        end else begin
          w_nextClkCnt = r_clkCnt + CW'(1);
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_nextClkCnt = '0;
          w_nextState  = IDLE;
        end else begin
          w_nextClkCnt = r_clkCnt + CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_txNext = 1'b1;
    case (w_nextState)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_nextShift[0];
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clkCnt  <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_byteCnt <= '0;
      r_tx      <= 1'b1;
      r_rdEn    <= 1'b0;
      r_busy    <= 1'b0;
      r_txDone  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_clkCnt <= w_nextClkCnt;
      r_bitIdx <= w_nextBitIdx;
      r_shift  <= w_nextShift;
      r_tx     <= w_txNext;
      r_rdEn   <= (w_nextState == REQ);
      r_busy   <= (w_nextState != IDLE);
      r_txDone <= (w_nextState == STOP) && (w_nextClkCnt == LAST);
      if ((r_state == STOP) && w_bitEnd) r_byteCnt <= r_byteCnt + 8'd1;
    end
  end

  assign tx         = r_tx;
  assign fifo_rd_en = r_rdEn;
  assign busy       = r_busy;
  assign tx_done    = r_txDone;
  assign byte_cnt   = r_byteCnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a pointer-based FIFO model and decodes the serial line
// back into bytes from a log of tx samples, comparing against the bytes that were queued.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_rd_en, tx, busy, tx_done;
  logic [7:0] byte_cnt;

  int checks   = 0;
  int failures = 0;
  int expCnt   = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] expCnt;
  } vecT;

  vecT singleVecs[4];
  vecT b2bVecs[3];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes move wrPtr (test side), pops move rdPtr on a sampled rd_en.
  logic [7:0] fifoMem[0:1023];
  int wrPtr = 0;
  int rdPtr = 0;
  int underflows = 0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rdPtr == wrPtr) underflows++;
      else begin
        fifo_data <= fifoMem[rdPtr % 1024];
        rdPtr++;
      end
    end
  end

  always @(posedge clk) begin
    #2 fifo_empty = (rdPtr == wrPtr);
  end

  // Line monitor: every tx sample is logged; strobes are counted outside reset.
  logic txLog[$];
  int rdPulses = 0;
  int rdWhileEmpty = 0;
  int donePulses = 0;

  always @(negedge clk) begin
    txLog.push_back(tx);
    if (!rst) begin
      if (fifo_rd_en) begin
        rdPulses++;
        if (fifo_empty) rdWhileEmpty++;
      end
      if (tx_done) donePulses++;
    end
  end

  logic [7:0] decBytes[$];
  int decStarts[$];
  logic [7:0] expQ[$];
  int logBase, rdBase, doneBase;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushNow(input logic [7:0] b);
    fifoMem[wrPtr % 1024] = b;
    wrPtr++;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1 pushNow(b);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    expCnt = 0;
  endtask

  task automatic snapshot();
    @(posedge clk);
    #1;
    logBase  = txLog.size();
    rdBase   = rdPulses;
    doneBase = donePulses;
  endtask

  task automatic findStart(output logic found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < 8) begin
      @(negedge clk);
      n++;
      if (fifo_empty == 1'b0) found = 1'b1;
    end
    checkOutput("emptyFall", {31'd0, found}, 32'd1);
  endtask

  task automatic waitDone(input int n, input int maxCycles, input string name);
    int seen;
    int cyc;
    logic pend;
    seen = 0;
    cyc = 0;
    pend = 1'b0;
    while ((seen < n || pend) && cyc < maxCycles) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        checkOutput({name, "_byteCnt"}, byte_cnt, expCnt);
        pend = 1'b0;
      end
      if (tx_done) begin
        seen++;
        expCnt = (expCnt + 1) % 256;
        pend = 1'b1;
      end
    end
    checkOutput({name, "_doneCount"}, seen, n);
  endtask

  // A frame is a 0 preceded by a 1, still 0 mid-start-bit, data sampled mid-bit, 1 mid-stop-bit.
  function automatic void decodeLog(input int base);
    int i;
    logic [7:0] b;
    decBytes.delete();
    decStarts.delete();
    i = base + 1;
    while (i + 38 < txLog.size()) begin
      if (txLog[i] == 1'b0 && txLog[i-1] == 1'b1 && txLog[i+2] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txLog[i + 6 + 4*k];
        if (txLog[i+38] == 1'b1) begin
          decBytes.push_back(b);
          decStarts.push_back(i);
        end
        i += 40;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic compareDecoded(input string name);
    checkOutput({name, "_numBytes"}, decBytes.size(), expQ.size());
    for (int j = 0; j < decBytes.size() && j < expQ.size(); j++)
      checkOutput($sformatf("%s_byte%0d", name, j), decBytes[j], expQ[j]);
  endtask

  // Cycle-exact frame check; k counts cycles from the one in which fifo_empty first reads low.
  task automatic runSingleFrame(input logic [7:0] data);
    logic found;
    logic expTx;
    logic [3:0] expSig;
    applyStimulus(data);
    findStart(found);
    if (found) begin
      for (int k = 0; k <= 43; k++) begin
        if (k > 0) @(negedge clk);
        if (k >= 3 && k <= 6)       expTx = 1'b0;
        else if (k >= 7 && k <= 38) expTx = data[(k - 7) / 4];
        else                        expTx = 1'b1;
        expSig = {expTx, (k == 1), (k >= 1 && k <= 42), (k == 42)};
        checkOutput($sformatf("frame%02h_k%0d", data, k), {tx, fifo_rd_en, busy, tx_done}, expSig);
      end
    end
  endtask

  task automatic resetMidFrame(input logic [7:0] data, input int offset, input string name);
    logic found;
    applyReset();
    snapshot();
    applyStimulus(data);
    findStart(found);
    repeat (offset) @(negedge clk);
    checkOutput({name, "_preBusy"}, busy, 1);
    #2 rst = 1'b1;
    #1 checkOutput({name, "_asyncRst"}, {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
    repeat (2) @(negedge clk);
    checkOutput({name, "_cntInRst"}, byte_cnt, 0);
    #2 rst = 1'b0;
    expCnt = 0;
    snapshot();
    checkOutput({name, "_cntAfter"}, byte_cnt, 0);
    expQ.delete();
    expQ.push_back(8'h81);
    applyStimulus(8'h81);
    waitDone(1, 100, name);
    repeat (4) @(negedge clk);
    decodeLog(logBase);
    compareDecoded(name);
    checkOutput({name, "_doneTotal"}, donePulses - doneBase, 1);
    checkOutput({name, "_cntFinal"}, byte_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    singleVecs[0] = '{8'hA5, 8'd1};
    singleVecs[1] = '{8'h01, 8'd2};
    singleVecs[2] = '{8'h80, 8'd3};
    singleVecs[3] = '{8'hF0, 8'd4};
    b2bVecs[0]    = '{8'h00, 8'd1};
    b2bVecs[1]    = '{8'hFF, 8'd2};
    b2bVecs[2]    = '{8'h55, 8'd3};

    $display("[TB] reset hold");
    applyReset();
    snapshot();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_k%0d", k), {tx, busy, fifo_rd_en, tx_done, byte_cnt}, {4'b1000, 8'h00});
    end
    checkOutput("idle_rdPulses", rdPulses - rdBase, 0);

    $display("[TB] single frames");
    for (int i = 0; i < 4; i++) begin
      runSingleFrame(singleVecs[i].data);
      checkOutput($sformatf("single%0d_cnt", i), byte_cnt, singleVecs[i].expCnt);
    end
    for (int j = 0; j < 3; j++) begin
      r = 8'($urandom_range(0, 255));
      runSingleFrame(r);
      checkOutput($sformatf("rand%0d_cnt", j), byte_cnt, 5 + j);
    end

    $display("[TB] back-to-back");
    applyReset();
    snapshot();
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      pushNow(b2bVecs[i].data);
      expQ.push_back(b2bVecs[i].data);
    end
    waitDone(3, 200, "b2b");
    repeat (4) @(negedge clk);
    decodeLog(logBase);
    compareDecoded("b2b");
    for (int j = 0; j + 1 < decStarts.size(); j++)
      checkOutput($sformatf("b2b_gap%0d", j), decStarts[j+1] - (decStarts[j] + 40), 3);
    checkOutput("b2b_rdPulses", rdPulses - rdBase, 3);
    checkOutput("b2b_cnt", byte_cnt, b2bVecs[2].expCnt);
    checkOutput("b2b_empty", fifo_empty, 1);

    $display("[TB] reset mid-frame");
    resetMidFrame(8'h3C, 20, "rstBit3");
    resetMidFrame(8'h3C, 4, "rstStart");

    $display("[TB] 256-byte wrap");
    applyReset();
    snapshot();
    expQ.delete();
    for (int i = 0; i < 256; i++) begin
      r = 8'($urandom_range(0, 255));
      pushNow(r);
      expQ.push_back(r);
    end
    waitDone(256, 256 * 45 + 50, "wrap");
    repeat (4) @(negedge clk);
    decodeLog(logBase);
    compareDecoded("wrap");
    checkOutput("wrap_cnt", byte_cnt, 0);

    $display("[TB] random-interval writes");
    applyReset();
    snapshot();
    expQ.delete();
    for (int i = 0; i < 8; i++) expQ.push_back(8'($urandom_range(0, 255)));
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(1, 60)) @(posedge clk);
          #1 pushNow(expQ[i]);
        end
      end
      begin
        waitDone(8, 1200, "stream");
      end
    join
    repeat (4) @(negedge clk);
    decodeLog(logBase);
    compareDecoded("stream");
    checkOutput("stream_rdPulses", rdPulses - rdBase, 8);

    checkOutput("rdWhileEmpty", rdWhileEmpty, 0);
    checkOutput("underflows", underflows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
